// File: rtl/bus_target_pkg.sv
// Shared definitions for the bus target responder: FSM states, default
// timing constants and the position of the read/write bit in a command byte.
package bus_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    TURN,
    DRIVE,
    RELEASE
  } state_t;

  localparam int DEF_DW       = 8;
  localparam int DEF_AW       = 2;
  localparam int DEF_TURN_CYC = 1;
  localparam int DEF_WAIT_MAX = 15;

  // The R/W flag is always the top bit of the command byte.
  function automatic int cmd_rw_bit(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/target_reg_file.sv
// Small register file shared by the bus initiator and local logic.
// Two write ports; when both hit the same entry in one cycle the host wins.
// Reads are asynchronous so the FSM can snapshot in the command cycle.
module target_reg_file #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          loc_we,
  input  logic [AW-1:0] loc_addr,
  input  logic [DW-1:0] loc_wdata,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] regs [NREG];

  // Per-entry write with host priority over the local port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (host_we && host_addr == AW'(i)) regs[i] <= host_wdata;
        else if (loc_we && loc_addr == AW'(i)) regs[i] <= loc_wdata;
      end
    end
  end

  assign rd_data = regs[rd_addr];

endmodule

// File: rtl/bus_target_responder.sv
// Target end of the shared bidirectional byte bus. Decodes command bytes,
// commits host writes, and returns read data after a fixed turnaround.
// Any initiator activity while we own the turnaround/drive window is a
// collision: we release the bus in that same cycle and flag a sticky error.
module bus_target_responder
  import bus_target_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int TURN_CYC = DEF_TURN_CYC,
  parameter int WAIT_MAX = DEF_WAIT_MAX
) (
  input  logic          clk,
  input  logic          reset,
  inout  wire  [DW-1:0] io_pin,
  input  logic          bus_req,
  input  logic          loc_wr_en,
  input  logic [AW-1:0] loc_addr,
  input  logic [DW-1:0] loc_wdata,
  output logic          drive_en,
  output logic          rsp_valid,
  output logic          host_wr,
  output logic [AW-1:0] host_wr_addr,
  output logic [DW-1:0] host_wr_data,
  output logic          busy,
  output logic          err
);

  localparam int RW_BIT = cmd_rw_bit(DW);
  localparam int TW     = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam int WW     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

  state_t        state;
  logic [AW-1:0] addr;
  logic [DW-1:0] rd_buf;
  logic [DW-1:0] rd_data;
  logic [TW-1:0] turn_cnt;
  logic [WW-1:0] wait_cnt;
  logic          drive_q;
  logic          host_we;

  assign host_we = (state == WDATA) && bus_req;

  target_reg_file #(
    .DW(DW),
    .AW(AW)
  ) u_regs (
    .clk       (clk),
    .reset     (reset),
    .host_we   (host_we),
    .host_addr (addr),
    .host_wdata(io_pin),
    .loc_we    (loc_wr_en),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .rd_addr   (io_pin[AW-1:0]),
    .rd_data   (rd_data)
  );

  // Transaction FSM: command decode, write-data wait, turnaround and drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      rd_buf       <= '0;
      turn_cnt     <= '0;
      wait_cnt     <= '0;
      drive_q      <= 1'b0;
      host_wr      <= 1'b0;
      host_wr_addr <= '0;
      host_wr_data <= '0;
      err          <= 1'b0;
    end else begin
      host_wr <= 1'b0;
      drive_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus_req) begin
            addr <= io_pin[AW-1:0];
            if (io_pin[RW_BIT]) begin
              rd_buf   <= rd_data;
              turn_cnt <= '0;
              state    <= TURN;
            end else begin
              wait_cnt <= '0;
              state    <= WDATA;
            end
          end
        end
        WDATA: begin
          if (bus_req) begin
            host_wr      <= 1'b1;
            host_wr_addr <= addr;
            host_wr_data <= io_pin;
            state        <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        TURN: begin
          if (bus_req) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (turn_cnt == TURN_LAST) begin
            drive_q <= 1'b1;
            state   <= DRIVE;
          end else begin
            turn_cnt <= turn_cnt + TW'(1);
          end
        end
        DRIVE: begin
          if (bus_req) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            state <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The registered drive flag is gated by bus_req so a collision frees the bus at once.
  assign drive_en  = drive_q & ~bus_req;
  assign rsp_valid = drive_en;
  assign busy      = (state != IDLE);
  assign io_pin    = drive_en ? rd_buf : {DW{1'bz}};

endmodule
